logisim_register_bank: RTL and testbench
========================================

# logisim_register_bank

Parametrised multi-word register bank: the successor to the single Logisim register primitive in the memory library. It holds NrOfWords words of NrOfBits each, with addressed write, shift-in and rotate modes, a saturating fill counter, and a tri-state addressed read port. It sits in the memory library beside the single-register primitive, for datapaths that need small line buffers or window registers, such as pixel/feature shift windows feeding the recognition datapath.

## Interface
Parameters:
- NrOfBits, 8, word width (1..32).
- NrOfWords, 4, number of words (2..16).
- AddrBits, 2, address width; ceil(log2(NrOfWords)).
- ActiveLevel, 1, 1 = all state updates on the rising edge of Clock; 0 = on the falling edge.

Ports:
- Clock  in  1  clock; active edge is set by ActiveLevel.
- Reset  in  1  reset, asynchronous, active-high.
- Pre  in  1  asynchronous preset, active-high; Reset has priority over Pre.
- ClockEnable  in  1  update enable.
- Tick  in  1  tick qualifier; an update requires ClockEnable & Tick.
- Mode  in  2  00 hold, 01 addressed write, 10 shift-in, 11 rotate.
- WrAddr  in  AddrBits  write word index (Mode 01).
- D  in  NrOfBits  write / shift-in data.
- RdAddr  in  AddrBits  read word index.
- cs  in  1  high = Q tri-stated (all bits z).
- Q  out  NrOfBits  word[RdAddr].
- ShiftOut  out  NrOfBits  word[NrOfWords-1], never tri-stated.
- Count  out  AddrBits+1  fill level, 0..NrOfWords.
- Full  out  1  Count == NrOfWords.

## Operation
- Storage: word[0..NrOfWords-1] plus Count.
- Reset high, asynchronously: all words = 0, Count = 0.
- Pre high and Reset low, asynchronously: all words = all ones, Count = NrOfWords.
- While Reset or Pre is held, no clocked update occurs.
- Clocked update happens on the active edge only when ClockEnable & Tick = 1. Otherwise all state holds.
- Mode 00: hold.
- Mode 01: word[WrAddr] <= D.
  - If WrAddr >= NrOfWords, the write is ignored.
  - Count is unchanged.
- Mode 10: word[0] <= D and word[i] <= word[i-1] for i >= 1; the old word[NrOfWords-1] is discarded.
  - Count <= Count+1, saturating at NrOfWords.
- Mode 11: word[0] <= word[NrOfWords-1] and word[i] <= word[i-1].
  - D is ignored; Count is unchanged.
- Q = cs ? z : (RdAddr < NrOfWords ? word[RdAddr] : 0). Q is combinational from the stored state.
- ShiftOut = word[NrOfWords-1], combinational.
- Full = (Count == NrOfWords), combinational.
- Only one edge domain is implemented, selected at elaboration. The design does not keep duplicate positive-edge and negative-edge copies.

## Timing
- Reset values: Q = 0 (when cs = 0), ShiftOut = 0, Count = 0, Full = 0.
- Write-to-read latency: 1 active edge. A read of the address being written in the same cycle returns the old value until the edge.
- Reset and Pre take effect immediately (asynchronous assertion). Deassertion is sampled at the next active edge: the first update can happen on the first active edge after release.
- Reset asserted mid-operation, e.g. mid-shift: all words and Count are cleared at once, and that cycle's pending update is lost.
- Reset and Pre asserted together: the reset result wins.
- Count saturation: once Count = NrOfWords, further shifts keep Count = NrOfWords and Full = 1. Only Reset clears Count.
- Tick low while ClockEnable is high: no update; Count does not advance.
- cs affects only Q and has no effect on state.

## Test plan
Defaults: NrOfBits = 8, NrOfWords = 4.
- Reset pulse, then Pre pulse, then Reset and Pre together. Required: after Reset, all words 00 and Count 0; after Pre, all words FF, Count 4, Full 1; after both, words 00 and Count 0.
- Mode 01, writes of 11/22/33/44 to addresses 0..3 (ClockEnable = Tick = 1). Required: reading RdAddr 0..3 gives 11, 22, 33, 44; Count stays 0.
- Mode 10, shift in A1, A2, A3, A4, A5. Required: Count goes 1, 2, 3, 4, 4; Full rises after the 4th edge; final words are A5, A4, A3, A2; ShiftOut = A2.
- Mode 11 from words 01, 02, 03, 04. Required: after one edge, words are 04, 01, 02, 03; after 4 edges, back to 01, 02, 03, 04; Count unchanged.
- Gating and tri-state, in three steps:
  - Tick = 0 with Mode 10: state unchanged.
  - cs = 1: Q all z while ShiftOut is still valid.
  - RdAddr out of range (NrOfWords = 3, RdAddr = 3): Q = 00.
- ActiveLevel = 0 instance: writes occur only on falling edges. Assert Reset between a write setup and its edge: the word stays 00.

Source files
------------

// File: rtl/logisim_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : logisim_register_bank
//  Purpose  : Multi-word register bank holding NrOfWords words of NrOfBits
//             each. Supports hold, addressed write, shift-in and rotate
//             modes, a saturating fill counter, and a tri-state addressed
//             read port.
//  Ports    :
//    Clock        - clock; the active edge is selected by ActiveLevel
//    Reset        - asynchronous active-high clear (beats Pre)
//    Pre          - asynchronous active-high preset to all ones / full
//    ClockEnable  - update enable
//    Tick         - update qualifier; an update needs ClockEnable & Tick
//    Mode         - 00 hold, 01 addressed write, 10 shift-in, 11 rotate
//    WrAddr       - word index for addressed write
//    D            - write / shift-in data
//    RdAddr       - read word index
//    cs           - high tri-states Q
//    Q            - word[RdAddr], or 0 when RdAddr is out of range
//    ShiftOut     - word[NrOfWords-1], never tri-stated
//    Count        - fill level 0..NrOfWords
//    Full         - Count == NrOfWords
//  Revision : 1.0 - initial release
// ============================================================================
module logisim_register_bank #(
    parameter int NrOfBits    = 8,
    parameter int NrOfWords   = 4,
    parameter int AddrBits    = 2,
    parameter int ActiveLevel = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Pre,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic [1:0]          Mode,
    input  logic [AddrBits-1:0] WrAddr,
    input  logic [NrOfBits-1:0] D,
    input  logic [AddrBits-1:0] RdAddr,
    input  logic                cs,
    output logic [NrOfBits-1:0] Q,
    output logic [NrOfBits-1:0] ShiftOut,
    output logic [AddrBits:0]   Count,
    output logic                Full
);

    localparam logic [1:0] c_MODE_HOLD   = 2'b00;
    localparam logic [1:0] c_MODE_WRITE  = 2'b01;
    localparam logic [1:0] c_MODE_SHIFT  = 2'b10;
    localparam logic [1:0] c_MODE_ROTATE = 2'b11;

    localparam logic [AddrBits:0] c_FULL_COUNT = (AddrBits+1)'(NrOfWords);
    localparam logic [AddrBits:0] c_COUNT_ONE  = (AddrBits+1)'(1);

    logic [NrOfWords-1:0][NrOfBits-1:0] words_q;
    logic [NrOfWords-1:0][NrOfBits-1:0] words_d;
    logic [AddrBits:0]                  count_q;
    logic [AddrBits:0]                  count_d;

    logic                w_update;
    logic [31:0]         w_wr_idx;
    logic [31:0]         w_rd_idx;
    logic [NrOfBits-1:0] w_rd_word;

    assign w_update = ClockEnable & Tick;
    assign w_wr_idx = 32'(WrAddr);
    assign w_rd_idx = 32'(RdAddr);

    // ------------------------------------------------------------------
    // Next-state logic. Gating is folded in here so the state registers
    // simply reload their own value when no update is qualified.
    // ------------------------------------------------------------------
    always_comb begin
        words_d = words_q;
        count_d = count_q;
        if (w_update) begin
            case (Mode)
                c_MODE_HOLD: begin
                    words_d = words_q;
                end
                c_MODE_WRITE: begin
                    // An address at or beyond NrOfWords matches no word,
                    // so such writes fall through as no-ops.
                    for (int i = 0; i < NrOfWords; i++) begin
                        if (w_wr_idx == i) begin
                            words_d[i] = D;
                        end
                    end
                end
                c_MODE_SHIFT: begin
                    words_d[0] = D;
                    for (int i = 1; i < NrOfWords; i++) begin
                        words_d[i] = words_q[i-1];
                    end
                    if (count_q != c_FULL_COUNT) begin
                        count_d = count_q + c_COUNT_ONE;
                    end
                end
                c_MODE_ROTATE: begin
                    words_d[0] = words_q[NrOfWords-1];
                    for (int i = 1; i < NrOfWords; i++) begin
                        words_d[i] = words_q[i-1];
                    end
                end
                default: begin
                    words_d = words_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers. Exactly one edge flavour is elaborated.
    // ------------------------------------------------------------------
    if (ActiveLevel != 0) begin : g_rising_edge
        always_ff @(posedge Clock or posedge Reset or posedge Pre) begin
            if (Reset) begin
                words_q <= '0;
                count_q <= '0;
            end else if (Pre) begin
                words_q <= '1;
                count_q <= c_FULL_COUNT;
            end else begin
                words_q <= words_d;
                count_q <= count_d;
            end
        end
    end else begin : g_falling_edge
        always_ff @(negedge Clock or posedge Reset or posedge Pre) begin
            if (Reset) begin
                words_q <= '0;
                count_q <= '0;
            end else if (Pre) begin
                words_q <= '1;
                count_q <= c_FULL_COUNT;
            end else begin
                words_q <= words_d;
                count_q <= count_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side. The loop-based mux yields 0 for an out-of-range RdAddr
    // without ever indexing past the array.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NrOfWords; i++) begin
            if (w_rd_idx == i) begin
                w_rd_word = words_q[i];
            end
        end
    end

    assign Q        = cs ? {NrOfBits{1'bz}} : w_rd_word;
    assign ShiftOut = words_q[NrOfWords-1];
    assign Count    = count_q;
    assign Full     = (count_q == c_FULL_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_logisim_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logisim_register_bank
//  Purpose  : Directed self-checking bench for logisim_register_bank.
//             Three instances: default rising-edge 4x8, a 3-word variant
//             sharing the same stimulus, and a falling-edge variant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logisim_register_bank;

    logic       Clock = 1'b0;
    logic       Reset, Pre, ClockEnable, Tick, cs;
    logic [1:0] Mode;
    logic [1:0] WrAddr, RdAddr;
    logic [7:0] D;

    wire  [7:0] Q, ShiftOut;
    wire  [2:0] Count;
    wire        Full;

    wire  [7:0] q3, shiftout3;
    wire  [2:0] count3;
    wire        full3;

    logic       n_Reset, n_Pre, n_ClockEnable, n_Tick, n_cs;
    logic [1:0] n_Mode, n_WrAddr, n_RdAddr;
    logic [7:0] n_D;
    wire  [7:0] n_Q, n_ShiftOut;
    wire  [2:0] n_Count;
    wire        n_Full;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    logisim_register_bank #(.NrOfBits(8), .NrOfWords(4), .AddrBits(2), .ActiveLevel(1)) u_dut (
        .Clock(Clock), .Reset(Reset), .Pre(Pre), .ClockEnable(ClockEnable), .Tick(Tick),
        .Mode(Mode), .WrAddr(WrAddr), .D(D), .RdAddr(RdAddr), .cs(cs),
        .Q(Q), .ShiftOut(ShiftOut), .Count(Count), .Full(Full)
    );

    logisim_register_bank #(.NrOfBits(8), .NrOfWords(3), .AddrBits(2), .ActiveLevel(1)) u_dut3 (
        .Clock(Clock), .Reset(Reset), .Pre(Pre), .ClockEnable(ClockEnable), .Tick(Tick),
        .Mode(Mode), .WrAddr(WrAddr), .D(D), .RdAddr(RdAddr), .cs(1'b0),
        .Q(q3), .ShiftOut(shiftout3), .Count(count3), .Full(full3)
    );

    logisim_register_bank #(.NrOfBits(8), .NrOfWords(4), .AddrBits(2), .ActiveLevel(0)) u_neg (
        .Clock(Clock), .Reset(n_Reset), .Pre(n_Pre), .ClockEnable(n_ClockEnable), .Tick(n_Tick),
        .Mode(n_Mode), .WrAddr(n_WrAddr), .D(n_D), .RdAddr(n_RdAddr), .cs(n_cs),
        .Q(n_Q), .ShiftOut(n_ShiftOut), .Count(n_Count), .Full(n_Full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pos_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        RdAddr = addr;
        #1;
        chk(tag, {24'h0, Q}, {24'h0, exp});
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Pre = 1'b0; ClockEnable = 1'b0; Tick = 1'b0; cs = 1'b0;
        Mode = 2'b00; WrAddr = 2'd0; RdAddr = 2'd0; D = 8'h00;
        n_Reset = 1'b1; n_Pre = 1'b0; n_ClockEnable = 1'b0; n_Tick = 1'b0; n_cs = 1'b0;
        n_Mode = 2'b00; n_WrAddr = 2'd0; n_RdAddr = 2'd0; n_D = 8'h00;
        #12;

        // ---------------- reset / preset ----------------
        chk("rst_count", {29'h0, Count}, 32'd0);
        chk("rst_full", {31'h0, Full}, 32'd0);
        chk("rst_shiftout", {24'h0, ShiftOut}, 32'h00);
        chk("rst_q", {24'h0, Q}, 32'h00);
        Reset = 1'b0;
        #1;
        Pre = 1'b1;
        #2;
        chk("pre_count", {29'h0, Count}, 32'd4);
        chk("pre_full", {31'h0, Full}, 32'd1);
        chk("pre_shiftout", {24'h0, ShiftOut}, 32'hFF);
        chk("pre_q", {24'h0, Q}, 32'hFF);
        chk("pre_count3", {29'h0, count3}, 32'd3);
        Pre = 1'b0;
        #1;
        Reset = 1'b1; Pre = 1'b1;
        #2;
        chk("both_count", {29'h0, Count}, 32'd0);
        chk("both_shiftout", {24'h0, ShiftOut}, 32'h00);
        chk("both_q", {24'h0, Q}, 32'h00);
        Reset = 1'b0; Pre = 1'b0;
        pos_step();

        // ---------------- addressed write ----------------
        ClockEnable = 1'b1; Tick = 1'b1; Mode = 2'b01;
        WrAddr = 2'd0; D = 8'h11; RdAddr = 2'd0;
        #1;
        chk("write_old_before_edge", {24'h0, Q}, 32'h00);
        pos_step();
        WrAddr = 2'd1; D = 8'h22; pos_step();
        WrAddr = 2'd2; D = 8'h33; pos_step();
        WrAddr = 2'd3; D = 8'h44; pos_step();
        Mode = 2'b00;
        rd_chk("write_rd0", 2'd0, 8'h11);
        rd_chk("write_rd1", 2'd1, 8'h22);
        rd_chk("write_rd2", 2'd2, 8'h33);
        rd_chk("write_rd3", 2'd3, 8'h44);
        chk("write_count", {29'h0, Count}, 32'd0);
        // 3-word bank: the write to address 3 is dropped, word 2 keeps 33
        RdAddr = 2'd2;
        #1;
        chk("w3_rd2", {24'h0, q3}, 32'h33);
        chk("w3_shiftout", {24'h0, shiftout3}, 32'h33);

        // ---------------- shift-in ----------------
        Mode = 2'b10;
        D = 8'hA1; pos_step(); chk("shift_count1", {29'h0, Count}, 32'd1);
        chk("shift_full1", {31'h0, Full}, 32'd0);
        D = 8'hA2; pos_step(); chk("shift_count2", {29'h0, Count}, 32'd2);
        D = 8'hA3; pos_step(); chk("shift_count3", {29'h0, Count}, 32'd3);
        chk("shift_full3", {31'h0, Full}, 32'd0);
        D = 8'hA4; pos_step(); chk("shift_count4", {29'h0, Count}, 32'd4);
        chk("shift_full4", {31'h0, Full}, 32'd1);
        D = 8'hA5; pos_step(); chk("shift_count5_sat", {29'h0, Count}, 32'd4);
        chk("shift_full5", {31'h0, Full}, 32'd1);
        Mode = 2'b00;
        rd_chk("shift_rd0", 2'd0, 8'hA5);
        rd_chk("shift_rd1", 2'd1, 8'hA4);
        rd_chk("shift_rd2", 2'd2, 8'hA3);
        rd_chk("shift_rd3", 2'd3, 8'hA2);
        chk("shift_shiftout", {24'h0, ShiftOut}, 32'hA2);
        chk("shift3_count_sat", {29'h0, count3}, 32'd3);

        // ---------------- rotate ----------------
        Mode = 2'b01;
        WrAddr = 2'd0; D = 8'h01; pos_step();
        WrAddr = 2'd1; D = 8'h02; pos_step();
        WrAddr = 2'd2; D = 8'h03; pos_step();
        WrAddr = 2'd3; D = 8'h04; pos_step();
        Mode = 2'b11; D = 8'hEE;
        pos_step();
        Mode = 2'b00;
        rd_chk("rot1_rd0", 2'd0, 8'h04);
        rd_chk("rot1_rd1", 2'd1, 8'h01);
        rd_chk("rot1_rd2", 2'd2, 8'h02);
        rd_chk("rot1_rd3", 2'd3, 8'h03);
        Mode = 2'b11;
        pos_step(); pos_step(); pos_step();
        Mode = 2'b00;
        rd_chk("rot4_rd0", 2'd0, 8'h01);
        rd_chk("rot4_rd1", 2'd1, 8'h02);
        rd_chk("rot4_rd2", 2'd2, 8'h03);
        rd_chk("rot4_rd3", 2'd3, 8'h04);
        chk("rot_count", {29'h0, Count}, 32'd4);

        // ---------------- gating and tri-state ----------------
        Mode = 2'b10; Tick = 1'b0; D = 8'hEE;
        pos_step();
        rd_chk("tick0_rd0", 2'd0, 8'h01);
        chk("tick0_shiftout", {24'h0, ShiftOut}, 32'h04);
        Mode = 2'b00; Tick = 1'b1;
        cs = 1'b1;
        RdAddr = 2'd3;
        #1;
        checks++;
        assert (Q === 8'bzzzz_zzzz) else begin
            failures++;
            $error("FAIL cs_tristate observed=%h expected=zz", Q);
        end
        chk("cs_shiftout", {24'h0, ShiftOut}, 32'h04);
        cs = 1'b0;
        #1;
        rd_chk("cs_release_rd3", 2'd3, 8'h04);
        RdAddr = 2'd3;
        #1;
        chk("w3_rd_out_of_range", {24'h0, q3}, 32'h00);

        // ---------------- falling-edge instance ----------------
        @(posedge Clock); #1;
        n_Reset = 1'b0;
        n_ClockEnable = 1'b1; n_Tick = 1'b1; n_Mode = 2'b01;
        n_WrAddr = 2'd0; n_D = 8'h5A; n_RdAddr = 2'd0;
        #1;
        chk("neg_before_edge", {24'h0, n_Q}, 32'h00);
        @(negedge Clock); #1;
        chk("neg_after_fall", {24'h0, n_Q}, 32'h5A);
        n_D = 8'h77;
        @(posedge Clock); #1;
        chk("neg_rise_no_write", {24'h0, n_Q}, 32'h5A);
        n_WrAddr = 2'd1; n_D = 8'h99;
        #1;
        n_Reset = 1'b1;
        @(negedge Clock); #1;
        n_RdAddr = 2'd1;
        #1;
        chk("neg_reset_blocks_write", {24'h0, n_Q}, 32'h00);
        n_RdAddr = 2'd0;
        #1;
        chk("neg_reset_clears_word0", {24'h0, n_Q}, 32'h00);
        n_Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
